ns_nd_1to2: RTL and testbench



---
 rtl/ns_nd_1to2.sv | 204 ++++++++++++++++++++
 tb/tb_ns_nd_1to2.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ns_nd_1to2.sv
`timescale 1ns/1ps
// ns_nd_1to2: one-input, two-output message router. Each inbound message is
// steered to port 0 or port 1 by comparing its destination field against one
// or two parameterised reference values. Every channel uses a four-phase
// req/ack handshake, and each incoming control line is resynchronised.

package ns_nd_1to2_pkg;
  localparam int unsigned NS_FALSE        = 0;
  localparam int unsigned NS_TRUE         = 1;
  localparam int unsigned NS_GT_OP        = 0;
  localparam int unsigned NS_GTE_OP       = 1;
  localparam int unsigned NS_LT_OP        = 2;
  localparam int unsigned NS_LTE_OP       = 3;
  localparam int unsigned NS_EQ_OP        = 4;
  localparam int unsigned NS_NEQ_OP       = 5;
  localparam int unsigned NS_ADDRESS_SIZE = 6;
  localparam int unsigned NS_DATA_SIZE    = 8;
  localparam int unsigned NS_REDUN_SIZE   = 4;
endpackage

module ns_nd_1to2
  import ns_nd_1to2_pkg::*;
#(
  parameter int unsigned OPER_1    = NS_GT_OP,
  parameter int unsigned REF_VAL_1 = 0,
  parameter int unsigned IS_RANGE  = NS_FALSE,
  parameter int unsigned OPER_2    = NS_GT_OP,
  parameter int unsigned REF_VAL_2 = 0,
  parameter int unsigned ASZ       = NS_ADDRESS_SIZE,
  parameter int unsigned DSZ       = NS_DATA_SIZE,
  parameter int unsigned RSZ       = NS_REDUN_SIZE
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [ASZ-1:0] i0_src,
  input  logic [ASZ-1:0] i0_dst,
  input  logic [DSZ-1:0] i0_dat,
  input  logic [RSZ-1:0] i0_red,
  input  logic           i0_req,
  output logic           i0_ack,
  output logic [ASZ-1:0] o0_src,
  output logic [ASZ-1:0] o0_dst,
  output logic [DSZ-1:0] o0_dat,
  output logic [RSZ-1:0] o0_red,
  output logic           o0_req,
  input  logic           o0_ack,
  output logic [ASZ-1:0] o1_src,
  output logic [ASZ-1:0] o1_dst,
  output logic [DSZ-1:0] o1_dat,
  output logic [RSZ-1:0] o1_red,
  output logic           o1_req,
  input  logic           o1_ack
);

  typedef struct packed {
    logic [ASZ-1:0] src;
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
    logic [RSZ-1:0] red;
  } msg_t;

  typedef enum logic [1:0] {IN_IDLE, IN_ROUTE, IN_ACK, IN_REL} in_state_e;
  typedef enum logic [1:0] {OUT_EMPTY, OUT_REQ, OUT_WAIT} out_state_e;

  localparam logic [ASZ-1:0] REF1 = ASZ'(REF_VAL_1);
  localparam logic [ASZ-1:0] REF2 = ASZ'(REF_VAL_2);

  function automatic logic cmp_f(input logic [ASZ-1:0] a, input int unsigned op,
                                 input logic [ASZ-1:0] r);
    logic res;
    case (op)
      NS_GT_OP:  res = (a >  r);
      NS_GTE_OP: res = (a >= r);
      NS_LT_OP:  res = (a <  r);
      NS_LTE_OP: res = (a <= r);
      NS_EQ_OP:  res = (a == r);
      NS_NEQ_OP: res = (a != r);
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

  logic [1:0] req_sync_q, ack0_sync_q, ack1_sync_q;
  logic       req_s;
  logic [1:0] ack_s;

  in_state_e  in_state_q, in_state_d;
  msg_t       hld_q, hld_d;
  logic       hld_rt_q, hld_rt_d;
  logic       i0_ack_q, i0_ack_d;
  logic [1:0] load;

  out_state_e out_state_q [2];
  out_state_e out_state_d [2];
  msg_t       out_msg_q [2];
  msg_t       out_msg_d [2];
  logic [1:0] out_req_q, out_req_d;

  msg_t       in_msg;
  logic       rt;

  assign req_s  = req_sync_q[1];
  assign ack_s  = {ack1_sync_q[1], ack0_sync_q[1]};
  assign in_msg = '{src: i0_src, dst: i0_dst, dat: i0_dat, red: i0_red};

  // Route test on the live destination; only sampled when capturing.
  always_comb begin
    rt = cmp_f(i0_dst, OPER_1, REF1);
    if (IS_RANGE == NS_TRUE) rt = rt && cmp_f(i0_dst, OPER_2, REF2);
  end

  // Input side: capture, wait for the target buffer, then complete the handshake.
  always_comb begin
    in_state_d = in_state_q;
    hld_d      = hld_q;
    hld_rt_d   = hld_rt_q;
    i0_ack_d   = i0_ack_q;
    load       = 2'b00;
    case (in_state_q)
      IN_IDLE: if (req_s) begin
        hld_d      = in_msg;
        hld_rt_d   = rt;
        in_state_d = IN_ROUTE;
      end
      IN_ROUTE: if (out_state_q[hld_rt_q] == OUT_EMPTY) begin
        load       = hld_rt_q ? 2'b10 : 2'b01;
        i0_ack_d   = 1'b1;
        in_state_d = IN_ACK;
      end
      IN_ACK: if (!req_s) begin
        i0_ack_d   = 1'b0;
        in_state_d = IN_REL;
      end
      IN_REL:  in_state_d = IN_IDLE;
      default: in_state_d = IN_IDLE;
    endcase
  end

  // Output side: one-deep buffer per port driving its own four-phase handshake.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      out_state_d[p] = out_state_q[p];
      out_msg_d[p]   = out_msg_q[p];
      out_req_d[p]   = out_req_q[p];
      case (out_state_q[p])
        OUT_EMPTY: if (load[p]) begin
          out_msg_d[p]   = hld_q;
          out_req_d[p]   = 1'b1;
          out_state_d[p] = OUT_REQ;
        end
        OUT_REQ: if (ack_s[p]) begin
          out_req_d[p]   = 1'b0;
          out_state_d[p] = OUT_WAIT;
        end
        OUT_WAIT: if (!ack_s[p]) out_state_d[p] = OUT_EMPTY;
        default:  out_state_d[p] = OUT_EMPTY;
      endcase
    end
  end

  // State, synchronizers and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_sync_q  <= '0;
      ack0_sync_q <= '0;
      ack1_sync_q <= '0;
      in_state_q  <= IN_IDLE;
      hld_q       <= '0;
      hld_rt_q    <= 1'b0;
      i0_ack_q    <= 1'b0;
      out_req_q   <= '0;
      for (int unsigned p = 0; p < 2; p++) begin
        out_state_q[p] <= OUT_EMPTY;
        out_msg_q[p]   <= '0;
      end
    end else begin
      req_sync_q  <= {req_sync_q[0], i0_req};
      ack0_sync_q <= {ack0_sync_q[0], o0_ack};
      ack1_sync_q <= {ack1_sync_q[0], o1_ack};
      in_state_q  <= in_state_d;
      hld_q       <= hld_d;
      hld_rt_q    <= hld_rt_d;
      i0_ack_q    <= i0_ack_d;
      out_req_q   <= out_req_d;
      for (int unsigned p = 0; p < 2; p++) begin
        out_state_q[p] <= out_state_d[p];
        out_msg_q[p]   <= out_msg_d[p];
      end
    end
  end

  assign i0_ack = i0_ack_q;
  assign o0_req = out_req_q[0];
  assign o1_req = out_req_q[1];
  assign o0_src = out_msg_q[0].src;
  assign o0_dst = out_msg_q[0].dst;
  assign o0_dat = out_msg_q[0].dat;
  assign o0_red = out_msg_q[0].red;
  assign o1_src = out_msg_q[1].src;
  assign o1_dst = out_msg_q[1].dst;
  assign o1_dat = out_msg_q[1].dat;
  assign o1_red = out_msg_q[1].red;

endmodule

// File: tb/tb_ns_nd_1to2.sv
`timescale 1ns/1ps
// Bench for ns_nd_1to2: DUT A routes on dst > 5, DUT B routes on 2 <= dst <= 4.
module tb_ns_nd_1to2;
  import ns_nd_1to2_pkg::*;

  localparam int unsigned ASZ = 6;
  localparam int unsigned DSZ = 8;
  localparam int unsigned RSZ = 4;

  typedef struct packed {
    logic [ASZ-1:0] src;
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
    logic [RSZ-1:0] red;
  } msg_t;

  typedef struct {
    msg_t        m;
    int unsigned cyc;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [ASZ-1:0] i_src = '0;
  logic [ASZ-1:0] i_dst = '0;
  logic [DSZ-1:0] i_dat = '0;
  logic [RSZ-1:0] i_red = '0;
  logic [1:0]     i_req = '0;
  logic [1:0]     i_ack;
  logic [1:0][1:0]          oreq;
  logic [1:0][1:0]          oack;
  logic [1:0][1:0][ASZ-1:0] osrc, odst;
  logic [1:0][1:0][DSZ-1:0] odat;
  logic [1:0][1:0][RSZ-1:0] ored;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  obs_t        obsq [2][2][$];
  int unsigned ack_rise_cyc [2];
  logic [1:0]  hold = '0;
  int unsigned ack_max = 3;
  msg_t        expq [2][$];

  ns_nd_1to2 #(.OPER_1(NS_GT_OP), .REF_VAL_1(5), .IS_RANGE(NS_FALSE), .OPER_2(NS_GT_OP),
               .REF_VAL_2(0), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) dut_a (
    .clk(clk), .reset(rst_n),
    .i0_src(i_src), .i0_dst(i_dst), .i0_dat(i_dat), .i0_red(i_red),
    .i0_req(i_req[0]), .i0_ack(i_ack[0]),
    .o0_src(osrc[0][0]), .o0_dst(odst[0][0]), .o0_dat(odat[0][0]), .o0_red(ored[0][0]),
    .o0_req(oreq[0][0]), .o0_ack(oack[0][0]),
    .o1_src(osrc[0][1]), .o1_dst(odst[0][1]), .o1_dat(odat[0][1]), .o1_red(ored[0][1]),
    .o1_req(oreq[0][1]), .o1_ack(oack[0][1])
  );

  ns_nd_1to2 #(.OPER_1(NS_GTE_OP), .REF_VAL_1(2), .IS_RANGE(NS_TRUE), .OPER_2(NS_LTE_OP),
               .REF_VAL_2(4), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) dut_b (
    .clk(clk), .reset(rst_n),
    .i0_src(i_src), .i0_dst(i_dst), .i0_dat(i_dat), .i0_red(i_red),
    .i0_req(i_req[1]), .i0_ack(i_ack[1]),
    .o0_src(osrc[1][0]), .o0_dst(odst[1][0]), .o0_dat(odat[1][0]), .o0_red(ored[1][0]),
    .o0_req(oreq[1][0]), .o0_ack(oack[1][0]),
    .o1_src(osrc[1][1]), .o1_dst(odst[1][1]), .o1_dat(odat[1][1]), .o1_red(ored[1][1]),
    .o1_req(oreq[1][1]), .o1_ack(oack[1][1])
  );

  // Reference routing rule for each configuration.
  function automatic int exp_port(input int d, input int unsigned dst);
    if (d == 0) return (dst > 5) ? 1 : 0;
    return (dst >= 2 && dst <= 4) ? 1 : 0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Logger: records every rising oX_req with the fields present and the cycle.
  initial begin
    logic [1:0][1:0] prev;
    logic [1:0]      aprev;
    obs_t            o;
    prev  = '0;
    aprev = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (i_ack[d] && !aprev[d]) ack_rise_cyc[d] = cyc;
        for (int p = 0; p < 2; p++) begin
          if (oreq[d][p] && !prev[d][p]) begin
            o.m   = '{src: osrc[d][p], dst: odst[d][p], dat: odat[d][p], red: ored[d][p]};
            o.cyc = cyc;
            obsq[d][p].push_back(o);
          end
        end
      end
      prev  = oreq;
      aprev = i_ack;
    end
  end

  // Receivers: random ack delay, port hold on DUT A, drop on reset.
  initial begin
    int unsigned wcnt [2][2];
    int unsigned wtgt [2][2];
    oack = '0;
    for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) begin
      wcnt[d][p] = 0;
      wtgt[d][p] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          if (!rst_n) oack[d][p] = 1'b0;
          else if (!oack[d][p] && oreq[d][p] && !(d == 0 && hold[p])) begin
            if (wcnt[d][p] >= wtgt[d][p]) begin
              oack[d][p] = 1'b1;
              wcnt[d][p] = 0;
              wtgt[d][p] = $urandom_range(0, ack_max);
            end else wcnt[d][p]++;
          end else if (oack[d][p] && !oreq[d][p]) oack[d][p] = 1'b0;
        end
      end
    end
  end

  task automatic send(input int d, input msg_t m, output int unsigned t_req, output bit ok);
    int n;
    ok = 1'b1;
    @(posedge clk); #1;
    i_src = m.src; i_dst = m.dst; i_dat = m.dat; i_red = m.red;
    i_req[d] = 1'b1;
    t_req = cyc;
    n = 0;
    while (!i_ack[d] && n < 300) begin @(negedge clk); n++; end
    if (!i_ack[d]) ok = 1'b0;
    @(posedge clk); #1;
    i_req[d] = 1'b0;
    n = 0;
    while (i_ack[d] && n < 300) begin @(negedge clk); n++; end
    if (i_ack[d]) ok = 1'b0;
  endtask

  task automatic wait_obs(input int d, input int p, input int n, input int limit);
    int k = 0;
    while (obsq[d][p].size() < n && k < limit) begin @(negedge clk); k++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (i_ack !== 2'b00) begin
      errors++; $display("FAIL reset_i0_ack: got %b want 00", i_ack);
    end
    checks++;
    if (oreq !== '0) begin
      errors++; $display("FAIL reset_oreq: got %b want 0000", oreq);
    end
    checks++;
    if ({osrc, odst, odat, ored} !== '0) begin
      errors++; $display("FAIL reset_fields: got %h want 0", {osrc, odst, odat, ored});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_route_port0();
    msg_t m = '{src: 6'd1, dst: 6'd3, dat: 8'd7, red: 4'd9};
    int p = exp_port(0, 3);
    int n0 = obsq[0][p].size();
    int n1 = obsq[0][1-p].size();
    int unsigned t;
    bit ok;
    send(0, m, t, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL p0_handshake: ok=%0d want 1", ok); end
    wait_obs(0, p, n0 + 1, 50);
    repeat (10) @(negedge clk);
    checks++;
    if (obsq[0][p].size() != n0 + 1) begin
      errors++; $display("FAIL p0_count: got %0d want %0d", obsq[0][p].size(), n0 + 1);
    end else begin
      checks++;
      if (obsq[0][p][n0].m !== m) begin
        errors++; $display("FAIL p0_fields: got %h want %h", obsq[0][p][n0].m, m);
      end
    end
    checks++;
    if (obsq[0][1-p].size() != n1) begin
      errors++; $display("FAIL p0_other_port: got %0d msgs want %0d", obsq[0][1-p].size(), n1);
    end
  endtask

  task automatic test_route_port1();
    msg_t m = '{src: 6'd2, dst: 6'd6, dat: 8'd8, red: 4'd5};
    int p = exp_port(0, 6);
    int n1 = obsq[0][p].size();
    int unsigned t;
    bit ok;
    int k;
    send(0, m, t, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL p1_handshake: ok=%0d want 1", ok); end
    wait_obs(0, p, n1 + 1, 50);
    checks++;
    if (obsq[0][p].size() != n1 + 1) begin
      errors++; $display("FAIL p1_count: got %0d want %0d", obsq[0][p].size(), n1 + 1);
    end else begin
      checks++;
      if (obsq[0][p][n1].m !== m) begin
        errors++; $display("FAIL p1_fields: got %h want %h", obsq[0][p][n1].m, m);
      end
      checks++;
      if (obsq[0][p][n1].cyc != ack_rise_cyc[0]) begin
        errors++;
        $display("FAIL p1_req_ack_same_edge: req cyc %0d ack cyc %0d", obsq[0][p][n1].cyc,
                 ack_rise_cyc[0]);
      end
    end
    checks++;
    if (ack_rise_cyc[0] != t + 4) begin
      errors++; $display("FAIL p1_latency: ack at %0d want %0d", ack_rise_cyc[0], t + 4);
    end
    k = 0;
    while ((oreq[0][p] || oack[0][p]) && k < 50) begin @(negedge clk); k++; end
    checks++;
    if ({oreq[0][p], oack[0][p]} !== 2'b00) begin
      errors++; $display("FAIL p1_four_phase: req/ack %b want 00", {oreq[0][p], oack[0][p]});
    end
  endtask

  task automatic test_range();
    int unsigned dsts [4] = '{1, 2, 4, 5};
    for (int i = 0; i < 4; i++) begin
      msg_t m;
      int p, n, no;
      int unsigned t;
      bit ok;
      m.src = 6'($urandom); m.dst = 6'(dsts[i]); m.dat = 8'($urandom); m.red = 4'($urandom);
      p = exp_port(1, dsts[i]);
      n = obsq[1][p].size();
      no = obsq[1][1-p].size();
      send(1, m, t, ok);
      wait_obs(1, p, n + 1, 50);
      repeat (8) @(negedge clk);
      checks++;
      if (!ok || obsq[1][p].size() != n + 1 || obsq[1][1-p].size() != no) begin
        errors++;
        $display("FAIL range_dst%0d: ok=%0d port%0d count %0d want %0d, other %0d want %0d",
                 dsts[i], ok, p, obsq[1][p].size(), n + 1, obsq[1][1-p].size(), no);
      end else begin
        checks++;
        if (obsq[1][p][n].m !== m) begin
          errors++; $display("FAIL range_fields_dst%0d: got %h want %h", dsts[i],
                             obsq[1][p][n].m, m);
        end
      end
    end
  endtask

  task automatic test_stall();
    msg_t m6 = '{src: 6'd10, dst: 6'd6, dat: 8'd60, red: 4'd1};
    msg_t m3 = '{src: 6'd11, dst: 6'd3, dat: 8'd30, red: 4'd2};
    msg_t m7 = '{src: 6'd12, dst: 6'd7, dat: 8'd70, red: 4'd3};
    int n0 = obsq[0][0].size();
    int n1 = obsq[0][1].size();
    int unsigned t;
    bit ok;
    hold[1] = 1'b1;
    send(0, m6, t, ok);
    send(0, m3, t, ok);
    wait_obs(0, 0, n0 + 1, 50);
    checks++;
    if (obsq[0][0].size() != n0 + 1) begin
      errors++; $display("FAIL stall_p0_count: got %0d want %0d", obsq[0][0].size(), n0 + 1);
    end else begin
      checks++;
      if (obsq[0][0][n0].m !== m3) begin
        errors++; $display("FAIL stall_p0_fields: got %h want %h", obsq[0][0][n0].m, m3);
      end
    end
    fork
      send(0, m7, t, ok);
      begin
        repeat (30) @(negedge clk);
        checks++;
        if (i_ack[0] !== 1'b0) begin
          errors++; $display("FAIL stall_i0_ack: got %b want 0", i_ack[0]);
        end
        checks++;
        if (obsq[0][1].size() != n1 + 1) begin
          errors++; $display("FAIL stall_p1_held: got %0d want %0d", obsq[0][1].size(), n1 + 1);
        end
        hold[1] = 1'b0;
      end
    join
    wait_obs(0, 1, n1 + 2, 100);
    checks++;
    if (!ok || obsq[0][1].size() != n1 + 2) begin
      errors++; $display("FAIL stall_release: ok=%0d count %0d want %0d", ok,
                         obsq[0][1].size(), n1 + 2);
    end else begin
      checks++;
      if (obsq[0][1][n1].m !== m6 || obsq[0][1][n1+1].m !== m7) begin
        errors++; $display("FAIL stall_order: got %h,%h want %h,%h", obsq[0][1][n1].m,
                           obsq[0][1][n1+1].m, m6, m7);
      end
    end
  endtask

  task automatic test_stream();
    int base [2];
    ack_max = 6;
    for (int p = 0; p < 2; p++) begin
      base[p] = obsq[0][p].size();
      expq[p].delete();
    end
    for (int i = 0; i < 16; i++) begin
      msg_t m;
      int unsigned t;
      bit ok;
      m.src = 6'($urandom);
      m.dst = (i % 2 == 0) ? 6'($urandom_range(0, 5)) : 6'($urandom_range(6, 63));
      m.dat = 8'(i * 3 + 1);
      m.red = 4'($urandom);
      expq[exp_port(0, m.dst)].push_back(m);
      send(0, m, t, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL stream_handshake_%0d: ok=%0d want 1", i, ok); end
    end
    for (int p = 0; p < 2; p++) wait_obs(0, p, base[p] + expq[p].size(), 400);
    repeat (20) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (obsq[0][p].size() != base[p] + expq[p].size()) begin
        errors++; $display("FAIL stream_count_p%0d: got %0d want %0d", p,
                           obsq[0][p].size() - base[p], expq[p].size());
      end else begin
        for (int j = 0; j < expq[p].size(); j++) begin
          checks++;
          if (obsq[0][p][base[p]+j].m !== expq[p][j]) begin
            errors++; $display("FAIL stream_p%0d_msg%0d: got %h want %h", p, j,
                               obsq[0][p][base[p]+j].m, expq[p][j]);
          end
        end
      end
    end
    ack_max = 3;
  endtask

  task automatic test_reset_mid();
    msg_t m = '{src: 6'd20, dst: 6'd2, dat: 8'd99, red: 4'd7};
    msg_t m2 = '{src: 6'd21, dst: 6'd9, dat: 8'd100, red: 4'd8};
    int k = 0;
    bit glitch = 1'b0;
    int n1;
    int unsigned t;
    bit ok;
    hold[0] = 1'b1;
    @(posedge clk); #1;
    i_src = m.src; i_dst = m.dst; i_dat = m.dat; i_red = m.red;
    i_req[0] = 1'b1;
    while (!i_ack[0] && k < 50) begin @(negedge clk); k++; end
    checks++;
    if ({oreq[0][0], i_ack[0]} !== 2'b11) begin
      errors++; $display("FAIL rstmid_pre: o0_req/i0_ack %b want 11", {oreq[0][0], i_ack[0]});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({oreq[0][0], i_ack[0]} !== 2'b00) begin
      errors++; $display("FAIL rstmid_async: o0_req/i0_ack %b want 00", {oreq[0][0], i_ack[0]});
    end
    checks++;
    if ({osrc[0][0], odst[0][0], odat[0][0], ored[0][0]} !== '0) begin
      errors++; $display("FAIL rstmid_fields: got %h want 0",
                         {osrc[0][0], odst[0][0], odat[0][0], ored[0][0]});
    end
    i_req[0] = 1'b0;
    hold[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i_ack[0] || oreq[0] != 2'b00) glitch = 1'b1;
    end
    checks++;
    if (glitch) begin errors++; $display("FAIL rstmid_glitch: got 1 want 0"); end
    n1 = obsq[0][1].size();
    send(0, m2, t, ok);
    wait_obs(0, 1, n1 + 1, 50);
    checks++;
    if (!ok || obsq[0][1].size() != n1 + 1) begin
      errors++; $display("FAIL rstmid_after: ok=%0d count %0d want %0d", ok,
                         obsq[0][1].size(), n1 + 1);
    end else begin
      checks++;
      if (obsq[0][1][n1].m !== m2) begin
        errors++; $display("FAIL rstmid_after_fields: got %h want %h", obsq[0][1][n1].m, m2);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_route_port0();
    test_route_port1();
    test_range();
    test_stall();
    test_stream();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
